// File: rtl/pid_pkg.sv
// pid_pkg: shared widths, saturation limits, sequencer states and the W-bit clip helper.
package pid_pkg;
  localparam int W = 6;
  localparam int ACC_W = 13;
  localparam int SAT_MAX = 31;
  localparam int SAT_MIN = -32;
  typedef enum logic [2:0] {IDLE, MUL_P, MUL_I, MUL_D, SUM} state_t;
  function automatic logic signed [W-1:0] sat(input logic signed [ACC_W-1:0] v);
    int x;
    x = int'(v);
    return (x > SAT_MAX) ? W'(SAT_MAX) : (x < SAT_MIN) ? W'(SAT_MIN) : W'(x);
  endfunction
endpackage

// File: rtl/pid_term_sequencer_mult.sv
// sat_serial_mult: serial multiply by repeated addition of a, b times; done one cycle after the count drains.
module sat_serial_mult
  import pid_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                start,
  input  logic signed [W-1:0] a,
  input  logic        [W-1:0] b,
  output logic                done,
  output logic signed [W-1:0] prod
);
  logic signed [ACC_W-1:0] acc;
  logic signed [W-1:0] a_r;
  logic [W-1:0] cnt;
  logic run;
  always_ff @(posedge clk)
    if (!rst_n) begin
      acc <= '0;
      a_r <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (ena) begin
      if (start) begin
        acc <= '0;
        a_r <= a;
        cnt <= b;
        run <= 1'b1;
      end else if (run) begin
        if (cnt == '0) run <= 1'b0;
        else begin
          acc <= acc + ACC_W'(a_r);
          cnt <= cnt - 1'b1;
        end
      end
    end
  assign done = run && cnt == '0;
  assign prod = sat(acc);
endmodule

// File: rtl/pid_term_sequencer.sv
// pid_term_sequencer: computes P, I and D terms back-to-back on one serial multiplier and sums them with saturation.
module pid_term_sequencer
  import pid_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                sample_valid,
  input  logic signed [W-1:0] err,
  input  logic        [W-1:0] kp,
  input  logic        [W-1:0] ki,
  input  logic        [W-1:0] kd,
  output logic                busy,
  output logic                out_valid,
  output logic signed [W-1:0] u,
  output logic                overrun
);
  state_t state;
  logic signed [W-1:0] e_r, integral, d_r, prev_err, p_r, i_r, dp_r;
  logic [W-1:0] kp_r, ki_r, kd_r;
  logic start_r, ov_r;
  logic mul_start, mul_done;
  logic signed [W-1:0] mul_a, mul_prod;
  logic [W-1:0] mul_b;
  logic signed [ACC_W-1:0] sum;
  // P is launched from the accept register; I and D launch in the cycle the previous term completes
  always_comb begin
    mul_start = start_r | (mul_done & (state == MUL_P | state == MUL_I));
    mul_a = start_r ? e_r : state == MUL_P ? integral : d_r;
    mul_b = start_r ? kp_r : state == MUL_P ? ki_r : kd_r;
    sum = ACC_W'(p_r) + ACC_W'(i_r) + ACC_W'(dp_r);
  end
  sat_serial_mult u_mult (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .start(mul_start),
    .a(mul_a),
    .b(mul_b),
    .done(mul_done),
    .prod(mul_prod)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      e_r <= '0;
      integral <= '0;
      d_r <= '0;
      prev_err <= '0;
      p_r <= '0;
      i_r <= '0;
      dp_r <= '0;
      kp_r <= '0;
      ki_r <= '0;
      kd_r <= '0;
      start_r <= 1'b0;
      ov_r <= 1'b0;
      busy <= 1'b0;
      u <= '0;
      overrun <= 1'b0;
    end else if (ena) begin
      start_r <= 1'b0;
      if (sample_valid && busy) overrun <= 1'b1;
      case (state)
        IDLE:
          if (busy) begin
            busy <= 1'b0;
            ov_r <= 1'b0;
          end else if (sample_valid) begin
            e_r <= err;
            kp_r <= kp;
            ki_r <= ki;
            kd_r <= kd;
            integral <= sat(ACC_W'(integral) + ACC_W'(err));
            d_r <= sat(ACC_W'(err) - ACC_W'(prev_err));
            prev_err <= err;
            busy <= 1'b1;
            start_r <= 1'b1;
            state <= MUL_P;
          end
        MUL_P:
          if (mul_done) begin
            p_r <= mul_prod;
            state <= MUL_I;
          end
        MUL_I:
          if (mul_done) begin
            i_r <= mul_prod;
            state <= MUL_D;
          end
        MUL_D:
          if (mul_done) begin
            dp_r <= mul_prod;
            state <= SUM;
          end
        SUM: begin
          u <= sat(sum);
          ov_r <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  assign out_valid = ov_r & ena;
endmodule

// File: tb/tb_pid_term_sequencer.sv
// tb_pid_term_sequencer: directed and randomized PID updates checked by a scoreboard against an arithmetic reference model.
module tb_pid_term_sequencer;
  import pid_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1, sample_valid = 1'b0;
  logic signed [W-1:0] err = '0;
  logic [W-1:0] kp = '0, ki = '0, kd = '0;
  logic busy, out_valid, overrun;
  logic signed [W-1:0] u;
  typedef struct {
    int u;
    int due;
    int blen;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int checks = 0, errors = 0, cyc = 0, brun = 0;
  int m_integ = 0, m_prev = 0, m_ovr = 0;

  pid_term_sequencer dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .sample_valid(sample_valid),
    .err(err),
    .kp(kp),
    .ki(ki),
    .kd(kd),
    .busy(busy),
    .out_valid(out_valid),
    .u(u),
    .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sat6(input int v);
    return v > 31 ? 31 : v < -32 ? -32 : v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: busy run length and every out_valid are compared against the scoreboard head
  always @(negedge clk) begin
    brun = busy ? brun + 1 : 0;
    if (out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got u=%0d expected no output (cycle %0d)", u, cyc);
      end else begin
        e = sb.pop_front();
        check("u", int'(u), e.u);
        check("latency", cyc, e.due);
        check("busy_len", brun, e.blen);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    sample_valid = 1'b0;
    ena = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_integ = 0;
    m_prev = 0;
    m_ovr = 0;
  endtask

  // One update: poke>0 pulses sample_valid in that busy cycle, drop_at>0 lowers ena for 5 cycles from there
  task automatic update(input int ev, input int gp, input int gi, input int gd, input int poke, input int drop_at);
    int d, uu, lat, a;
    bit seen;
    @(posedge clk);
    #1 err = W'(ev);
    kp = W'(gp);
    ki = W'(gi);
    kd = W'(gd);
    sample_valid = 1'b1;
    ena = 1'b1;
    a = cyc;
    m_integ = sat6(m_integ + ev);
    d = sat6(ev - m_prev);
    m_prev = ev;
    uu = sat6(sat6(gp * ev) + sat6(gi * m_integ) + sat6(gd * d));
    lat = gp + gi + gd + 6 + (drop_at > 0 ? 5 : 0);
    sb.push_back('{uu, a + lat, lat});
    seen = 1'b0;
    for (int k = 1; k <= 450 && !seen; k++) begin
      @(posedge clk);
      #1 sample_valid = (k == poke);
      if (k == poke) begin
        err = W'($urandom_range(0, 63));
        m_ovr = 1;
      end
      ena = !(drop_at > 0 && k >= drop_at && k < drop_at + 5);
      @(negedge clk);
      seen = out_valid;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no out_valid expected one within 450 cycles (cycle %0d)", cyc);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test expected finish before time limit");
    $fatal(1);
  end

  initial begin
    do_reset();
    @(negedge clk);
    check("rst_u", int'(u), 0);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_overrun", overrun, 0);
    update(5, 2, 0, 0, 0, 0);
    update(-1, 63, 0, 0, 0, 0);
    update(1, 63, 0, 0, 0, 0);
    do_reset();
    update(3, 0, 0, 1, 0, 0);
    update(-3, 0, 0, 1, 0, 0);
    repeat (3) update(31, 0, 1, 0, 0, 0);
    update(-1, 0, 1, 0, 0, 0);
    check("overrun_clear", overrun, 0);
    update(2, 10, 0, 0, 3, 0);
    check("overrun_set", overrun, 1);
    // Reset in the middle of a kp=10 update must discard the result
    @(posedge clk);
    #1 err = 6'sd7;
    kp = 6'd10;
    ki = '0;
    kd = '0;
    sample_valid = 1'b1;
    @(posedge clk);
    #1 sample_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_integ = 0;
    m_prev = 0;
    m_ovr = 0;
    @(negedge clk);
    check("midrst_u", int'(u), 0);
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_overrun", overrun, 0);
    repeat (30) @(negedge clk);
    update(2, 4, 0, 0, 0, 3);
    for (int n = 0; n < 25; n++) begin
      int ev, gp, gi, gd, poke;
      ev = int'($urandom_range(0, 63)) - 32;
      gp = int'($urandom_range(0, 63));
      gi = int'($urandom_range(0, 63));
      gd = int'($urandom_range(0, 63));
      poke = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, gp + gi + gd + 6)) : 0;
      update(ev, gp, gi, gd, poke, 0);
    end
    repeat (3) @(negedge clk);
    check("overrun_final", overrun, m_ovr);
    check("sb_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
